// File: rtl/sram_dp_reader_pkg.sv
// Shared definitions for the sram_dp read engine.
//   rd_state_t     : FSM encoding (IDLE, RUN, DRAIN, DONE)
//   FIFO_DEPTH     : pair FIFO depth; also the issue credit limit
//   FIFO_CNT_W     : width of the FIFO occupancy count (0..FIFO_DEPTH)
//   payload layout : {last, single, hi, lo}, 2*WIDTH+2 bits per pair
package sram_dp_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Two flag bits (last, single) sit above the two data words.
    localparam int PAYLOAD_FLAGS = 2;

    function automatic int payload_width(input int width);
        return 2 * width + PAYLOAD_FLAGS;
    endfunction

    function automatic int last_bit(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int single_bit(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/sram_dp_reader_fifo.sv
// sram_rd_fifo: synchronous FIFO holding read pairs until downstream accepts them.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data : write one payload (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_data         : head entry, stable until popped
//   o_count        : number of stored entries
//   o_empty        : no entries stored
module sram_rd_fifo
    import sram_dp_reader_pkg::*;
#(
    parameter int DATA_W = 34
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_pop,
    output logic [DATA_W-1:0]     o_data,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_CNT_W-1:0] FULL_COUNT = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [FIFO_CNT_W-1:0] ONE_ENTRY = FIFO_CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign o_empty = (o_count == '0);
    assign push_ok = i_push && (o_count != FULL_COUNT);
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // Storage needs no reset: the head is only looked at while the count is nonzero.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // A simultaneous push and pop leaves the count unchanged; the pointers
    // still move independently, so ordering is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push_ok, pop_ok})
                2'b10:   o_count <= o_count + ONE_ENTRY;
                2'b01:   o_count <= o_count - ONE_ENTRY;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_dp_reader.sv
// sram_dp_reader: streams a contiguous block out of the dual-port SRAM, one
// word pair per cycle (port 0 even offsets, port 1 odd offsets), into a
// valid/ready stream buffered by a 4-entry FIFO.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_start, i_base_addr, i_len : block command, accepted only in IDLE
//   o_busy, o_done            : not-IDLE flag, one-cycle completion pulse
//   o_ce_n, o_rdwr_n_*, o_addr_*, o_wdata_*, i_rdata_* : SRAM ports 0/1
//   o_valid, i_ready, o_data, o_single, o_last : pair stream
module sram_dp_reader
    import sram_dp_reader_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [ADDR_WIDTH:0]     i_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ce_n,
    output logic                    o_rdwr_n_0,
    output logic                    o_rdwr_n_1,
    output logic [ADDR_WIDTH-1:0]   o_addr_0,
    output logic [ADDR_WIDTH-1:0]   o_addr_1,
    output logic [WIDTH-1:0]        o_wdata_0,
    output logic [WIDTH-1:0]        o_wdata_1,
    input  logic [WIDTH-1:0]        i_rdata_0,
    input  logic [WIDTH-1:0]        i_rdata_1,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*WIDTH-1:0]      o_data,
    output logic                    o_single,
    output logic                    o_last
);

    localparam int PW = payload_width(WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE_PAIR = (ADDR_WIDTH + 1)'(1);
    localparam logic [FIFO_CNT_W:0] FIFO_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    rd_state_t               state;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [ADDR_WIDTH:0]     pairs_left;
    logic                    odd_len;
    logic                    s1_valid, s1_last, s1_single;
    logic                    s2_valid, s2_last, s2_single;
    logic [PW-1:0]           push_data;
    logic [PW-1:0]           head;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    fifo_empty;
    logic                    pop;
    logic                    can_issue;
    logic [ADDR_WIDTH:0]     start_pairs;
    logic [FIFO_CNT_W:0]     occupancy;

    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [31:0] inc);
        return ADDR_WIDTH'((32'(a) + inc) % DEPTH);
    endfunction

    assign o_rdwr_n_0 = 1'b1;
    assign o_rdwr_n_1 = 1'b1;
    assign o_wdata_0  = '0;
    assign o_wdata_1  = '0;

    assign start_pairs = (i_len >> 1) + {{ADDR_WIDTH{1'b0}}, i_len[0]};

    // Credits count stored pairs plus both in-flight stages; a pop in the
    // same cycle is deliberately not credited, which keeps this a pure
    // function of registers and still allows one issue per cycle.
    assign occupancy = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, s1_valid}
                     + {{FIFO_CNT_W{1'b0}}, s2_valid};
    assign can_issue = (occupancy < FIFO_LIMIT);

    // The odd tail word's partner read still happens; its data is zeroed here.
    assign push_data = {s2_last, s2_single, (s2_single ? {WIDTH{1'b0}} : i_rdata_1), i_rdata_0};

    assign o_valid  = !fifo_empty;
    assign pop      = o_valid && i_ready;
    assign o_data   = o_valid ? head[2*WIDTH-1:0] : '0;
    assign o_single = o_valid && head[single_bit(WIDTH)];
    assign o_last   = o_valid && head[last_bit(WIDTH)];

    sram_rd_fifo #(
        .DATA_W (PW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (s2_valid),
        .i_data  (push_data),
        .i_pop   (pop),
        .o_data  (head),
        .o_count (fifo_count),
        .o_empty (fifo_empty)
    );

    // Control FSM plus the two-stage read pipeline. The first pair is issued
    // on the start edge itself so data reaches the FIFO two edges later.
    // s1 marks the SRAM issue cycle, s2 the cycle its read data is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ce_n     <= 1'b1;
            o_addr_0   <= '0;
            o_addr_1   <= '0;
            next_addr  <= '0;
            pairs_left <= '0;
            odd_len    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_single  <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_single  <= 1'b0;
        end else begin
            o_ce_n    <= 1'b1;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_single <= 1'b0;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_single <= s1_single;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_len == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state      <= RUN;
                            o_ce_n     <= 1'b0;
                            o_addr_0   <= i_base_addr;
                            o_addr_1   <= wrap_addr(i_base_addr, 32'd1);
                            next_addr  <= wrap_addr(i_base_addr, 32'd2);
                            pairs_left <= start_pairs - ONE_PAIR;
                            odd_len    <= i_len[0];
                            s1_valid   <= 1'b1;
                            s1_last    <= (start_pairs == ONE_PAIR);
                            s1_single  <= (start_pairs == ONE_PAIR) && i_len[0];
                        end
                    end
                end
                RUN: begin
                    // Nothing left after the start-edge issue: go straight to draining.
                    if (pairs_left == '0) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        o_ce_n     <= 1'b0;
                        o_addr_0   <= next_addr;
                        o_addr_1   <= wrap_addr(next_addr, 32'd1);
                        next_addr  <= wrap_addr(next_addr, 32'd2);
                        pairs_left <= pairs_left - ONE_PAIR;
                        s1_valid   <= 1'b1;
                        s1_last    <= (pairs_left == ONE_PAIR);
                        s1_single  <= (pairs_left == ONE_PAIR) && odd_len;
                        if (pairs_left == ONE_PAIR) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && o_last) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dp_reader.sv
// Self-checking bench for sram_dp_reader: a behavioural SRAM, a pair
// scoreboard fed when each block is started, a table of block reads and a
// few hand-written multi-cycle sequences.
module tb_sram_dp_reader;

    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_start;
    logic [AW-1:0]      i_base_addr;
    logic [AW:0]        i_len;
    logic               o_busy;
    logic               o_done;
    logic               o_ce_n;
    logic               o_rdwr_n_0;
    logic               o_rdwr_n_1;
    logic [AW-1:0]      o_addr_0;
    logic [AW-1:0]      o_addr_1;
    logic [WIDTH-1:0]   o_wdata_0;
    logic [WIDTH-1:0]   o_wdata_1;
    logic [WIDTH-1:0]   i_rdata_0 = '0;
    logic [WIDTH-1:0]   i_rdata_1 = '0;
    logic               o_valid;
    logic               i_ready;
    logic [2*WIDTH-1:0] o_data;
    logic               o_single;
    logic               o_last;

    sram_dp_reader #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ce_n      (o_ce_n),
        .o_rdwr_n_0  (o_rdwr_n_0),
        .o_rdwr_n_1  (o_rdwr_n_1),
        .o_addr_0    (o_addr_0),
        .o_addr_1    (o_addr_1),
        .o_wdata_0   (o_wdata_0),
        .o_wdata_1   (o_wdata_1),
        .i_rdata_0   (i_rdata_0),
        .i_rdata_1   (i_rdata_1),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_single    (o_single),
        .o_last      (o_last)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural sram_dp: captures the address on the edge after issue and
    // presents the word for the following cycle.
    logic [WIDTH-1:0] sramMem [DEPTH];
    always @(posedge i_clk) begin
        if (!o_ce_n) begin
            i_rdata_0 <= sramMem[o_addr_0];
            i_rdata_1 <= sramMem[o_addr_1];
        end
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Scoreboards: expected pairs {last, single, hi, lo} and issued address pairs.
    logic [2*WIDTH+1:0] expQ[$];
    logic [2*AW-1:0]    expAddrQ[$];

    // Per-block observations gathered by the monitor.
    int         popsBlk, issuesBlk, doneCount, doneBefore;
    int         startCyc, firstValidCyc, lastPopCyc, doneCyc;
    bit         seenValid, firstPopSeen;
    logic [31:0] firstPopData, lastPopData;
    logic        lastPopSingle, lastPopLast;
    logic [2*WIDTH+1:0] expPair;
    logic [2*AW-1:0]    expAddr;

    initial begin
        doneCount = 0;
        popsBlk = 0;
        issuesBlk = 0;
    end

    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (!o_ce_n) begin
                issuesBlk++;
                checkOutput("issueExpected", 64'(expAddrQ.size() != 0), 64'd1);
                if (expAddrQ.size() != 0) begin
                    expAddr = expAddrQ.pop_front();
                    checkOutput("issueAddr", {o_addr_0, o_addr_1}, expAddr);
                end
            end
            if (o_valid && !seenValid) begin
                seenValid     = 1'b1;
                firstValidCyc = cyc;
            end
            if (o_valid && i_ready) begin
                popsBlk++;
                lastPopCyc    = cyc;
                lastPopData   = o_data;
                lastPopSingle = o_single;
                lastPopLast   = o_last;
                if (!firstPopSeen) begin
                    firstPopSeen = 1'b1;
                    firstPopData = o_data;
                end
                checkOutput("popExpected", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    expPair = expQ.pop_front();
                    checkOutput("pairData", o_data, expPair[2*WIDTH-1:0]);
                    checkOutput("pairFlags", {o_last, o_single}, expPair[2*WIDTH+1:2*WIDTH]);
                end
            end
            if (o_done) begin
                doneCount++;
                doneCyc = cyc;
            end
        end
    end

    function automatic void pushExpected(input logic [AW-1:0] base, input logic [AW:0] len);
        int pairs;
        int a;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        bit isLast;
        bit single;
        pairs = (int'(len) + 1) / 2;
        for (int p = 0; p < pairs; p++) begin
            a      = (int'(base) + 2 * p) % DEPTH;
            lo     = sramMem[a];
            hi     = sramMem[(a + 1) % DEPTH];
            isLast = (p == pairs - 1);
            single = isLast && len[0];
            if (single) hi = '0;
            expQ.push_back({isLast, single, hi, lo});
            expAddrQ.push_back({AW'(a), AW'((a + 1) % DEPTH)});
        end
    endfunction

    // Called at #1 after a rising edge; returns #1 after the start edge.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len);
        pushExpected(base, len);
        popsBlk       = 0;
        issuesBlk     = 0;
        seenValid     = 1'b0;
        firstPopSeen  = 1'b0;
        firstValidCyc = -1;
        lastPopCyc    = -1;
        doneCyc       = -1;
        doneBefore    = doneCount;
        i_start       = 1'b1;
        i_base_addr   = base;
        i_len         = len;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        startCyc = cyc;
    endtask

    task automatic waitForDone(input int maxCycles, input bit randomReady);
        int n = 0;
        while (doneCount == doneBefore && n < maxCycles) begin
            @(posedge i_clk);
            #1;
            if (randomReady) i_ready = 1'($urandom_range(0, 1));
            n++;
        end
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput("doneCount", 64'(doneCount - doneBefore), 64'd1);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        bit            randomReady;
        int            pairs;
        logic [31:0]   firstData;
        logic [31:0]   lastData;
        bit            lastSingle;
    } vector_t;

    vector_t vectors[6];

    initial begin
        // Absolute watchdog so the run always ends.
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_len       = '0;
        i_ready     = 1'b1;
        for (int i = 0; i < DEPTH; i++) sramMem[i] = 16'hA000 + 16'(i);

        vectors[0] = '{4'd0,  5'd8,  1'b0, 4, 32'hA001A000, 32'hA007A006, 1'b0};
        vectors[1] = '{4'd14, 5'd5,  1'b0, 3, 32'hA00FA00E, 32'h0000A002, 1'b1};
        vectors[2] = '{4'd3,  5'd1,  1'b0, 1, 32'h0000A003, 32'h0000A003, 1'b1};
        vectors[3] = '{4'd5,  5'd16, 1'b1, 8, 32'hA006A005, 32'hA004A003, 1'b0};
        vectors[4] = '{4'd9,  5'd7,  1'b1, 4, 32'hA00AA009, 32'h0000A00F, 1'b1};
        vectors[5] = '{4'd15, 5'd2,  1'b0, 1, 32'hA000A00F, 32'hA000A00F, 1'b0};

        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rstCeN",   o_ce_n, 1);
        checkOutput("rstAddr",  {o_addr_0, o_addr_1}, 0);
        checkOutput("rstBusy",  o_busy, 0);
        checkOutput("rstDone",  o_done, 0);
        checkOutput("rstValid", o_valid, 0);
        checkOutput("rstData",  o_data, 0);
        checkOutput("rstFlags", {o_single, o_last}, 0);
        checkOutput("tiedRdwr", {o_rdwr_n_0, o_rdwr_n_1}, 2'b11);
        checkOutput("tiedWdata", {o_wdata_0, o_wdata_1}, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        $display("[TB] table-driven block reads");
        for (int v = 0; v < 6; v++) begin
            i_ready = 1'b1;
            applyStimulus(vectors[v].base, vectors[v].len);
            checkOutput("busyAfterStart", o_busy, 1);
            waitForDone(200, vectors[v].randomReady);
            checkOutput("pops", popsBlk, vectors[v].pairs);
            checkOutput("issues", issuesBlk, vectors[v].pairs);
            checkOutput("firstValidLatency", 64'(firstValidCyc - startCyc), 2);
            checkOutput("doneAfterLastPop", 64'(doneCyc - lastPopCyc), 1);
            checkOutput("firstData", firstPopData, vectors[v].firstData);
            checkOutput("lastData", lastPopData, vectors[v].lastData);
            checkOutput("lastSingle", lastPopSingle, vectors[v].lastSingle);
            checkOutput("lastFlag", lastPopLast, 1);
            checkOutput("busyAfterDone", o_busy, 0);
        end

        $display("[TB] zero-length block");
        applyStimulus(4'd4, 5'd0);
        checkOutput("len0Done", o_done, 1);
        checkOutput("len0Busy", o_busy, 1);
        waitForDone(20, 1'b0);
        checkOutput("len0DoneTiming", 64'(doneCyc - startCyc), 0);
        checkOutput("len0Issues", issuesBlk, 0);
        checkOutput("len0Valid", seenValid, 0);

        $display("[TB] backpressure");
        i_ready = 1'b0;
        applyStimulus(4'd0, 5'd16);
        for (int n = 0; n < 20 && !seenValid; n++) begin
            @(posedge i_clk);
            #1;
        end
        checkOutput("bpValidSeen", seenValid, 1);
        for (int n = 0; n < 10; n++) begin
            @(posedge i_clk);
            #1;
            checkOutput("bpHoldValid", o_valid, 1);
            checkOutput("bpHoldData", o_data, 32'hA001A000);
            checkOutput("bpHoldLast", o_last, 0);
        end
        checkOutput("bpIssues", issuesBlk, 4);
        checkOutput("bpCeN", o_ce_n, 1);
        i_ready = 1'b1;
        waitForDone(100, 1'b0);
        checkOutput("bpPops", popsBlk, 8);
        checkOutput("bpLastData", lastPopData, 32'hA00FA00E);

        $display("[TB] reset mid-block");
        i_ready = 1'b1;
        applyStimulus(4'd0, 5'd16);
        for (int n = 0; n < 20 && issuesBlk < 3; n++) begin
            @(posedge i_clk);
            #1;
        end
        checkOutput("midIssuesReached", 64'(issuesBlk >= 3), 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midRstCeN",   o_ce_n, 1);
        checkOutput("midRstAddr",  {o_addr_0, o_addr_1}, 0);
        checkOutput("midRstBusy",  o_busy, 0);
        checkOutput("midRstDone",  o_done, 0);
        checkOutput("midRstValid", o_valid, 0);
        checkOutput("midRstData",  o_data, 0);
        checkOutput("midRstFlags", {o_single, o_last}, 0);
        expQ.delete();
        expAddrQ.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("midNoDone", 64'(doneCount - doneBefore), 0);
        applyStimulus(4'd6, 5'd2);
        waitForDone(50, 1'b0);
        checkOutput("postRstPops", popsBlk, 1);
        checkOutput("postRstData", lastPopData, 32'hA007A006);

        $display("[TB] start while busy");
        i_ready = 1'b1;
        applyStimulus(4'd2, 5'd6);
        i_start     = 1'b1;
        i_base_addr = 4'd10;
        i_len       = 5'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        waitForDone(50, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("busyStartPops", popsBlk, 3);
        checkOutput("busyStartIssues", issuesBlk, 3);
        checkOutput("busyStartDones", 64'(doneCount - doneBefore), 1);
        checkOutput("busyStartLast", lastPopData, 32'hA007A006);
        checkOutput("busyStartIdle", o_busy, 0);

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 0);
        checkOutput("addrScoreboardEmpty", 64'(expAddrQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_dp_reader.md
Name: sram_dp_reader

Overview:
- Initiator-side read engine for the `sram_dp` dual-port SRAM.
- On a start command it streams a contiguous block of words out of the SRAM, two words per cycle, using port 0 for even offsets and port 1 for odd offsets.
- Words are presented as a valid/ready stream of word pairs; downstream backpressure is absorbed by an internal 4-entry FIFO.
- Sits between `sram_dp` and the FrodoKEM arithmetic datapath (matrix/vector operand fetch).

Parameters:
- WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width.
- DEPTH, 1<<ADDR_WIDTH, SRAM word count; address arithmetic wraps modulo DEPTH.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  first word address.
- i_len  in  ADDR_WIDTH+1  number of words to read, 0..DEPTH.
- o_busy  out  1  high whenever not IDLE.
- o_done  out  1  one-cycle pulse when the final pair is popped, or for len=0.
- o_ce_n  out  1  SRAM chip enable, active low, shared by both ports.
- o_rdwr_n_0, o_rdwr_n_1  out  1 each  tied to 1 (read).
- o_addr_0, o_addr_1  out  ADDR_WIDTH each  SRAM read addresses.
- o_wdata_0, o_wdata_1  out  WIDTH each  tied to 0.
- i_rdata_0, i_rdata_1  in  WIDTH each  SRAM read data; valid the cycle after the issue cycle.
- o_valid  out  1  stream data valid.
- i_ready  in  1  stream consumer ready.
- o_data  out  2*WIDTH  {word at offset 2n+1, word at offset 2n}.
- o_single  out  1  only the low half of o_data is meaningful; upper half is 0.
- o_last  out  1  marks the final pair of the block.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE and the FIFO is emptied.
  - o_ce_n=1, addresses=0, o_busy=0, o_done=0, o_valid=0, o_data=0, o_single=0, o_last=0.
  - Reset asserted mid-block aborts the block immediately; no o_done is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN: on i_start with i_len>0. The block's base address and length are latched at this edge.
  - IDLE to DONE: on i_start with i_len==0. No SRAM access occurs.
  - RUN to DRAIN: on the edge that issues the last pair.
  - DRAIN to DONE: on the edge where the pair marked o_last pops (o_valid & i_ready).
  - DONE to IDLE: unconditionally after one cycle. o_done=1 only while in DONE.
  - i_start is ignored outside IDLE.
- Issue (all SRAM control outputs are registered):
  - A pair issued at edge k drives o_ce_n=0, o_addr_0=A and o_addr_1=(A+1) mod DEPTH during cycle k..k+1.
  - The SRAM captures at edge k+1. i_rdata is sampled into the FIFO at edge k+2.
  - A advances by 2 mod DEPTH per issue.
  - o_ce_n=1 in every cycle with no issue.
- Flow control:
  - Issue at an edge only if (FIFO count + pairs in flight) < 4.
  - In-flight stages are two: the issue cycle and the capture-pending cycle. Pops in the same cycle are not credited.
  - This guarantees no overflow and sustains 1 pair/cycle when i_ready is held high.
- Odd length: the final pair sets o_single=1 and forces the upper WIDTH bits of o_data to 0. Port 1 is still read, and its result is discarded.
- Latency: with i_start at edge k, o_valid is first high after edge k+2.
- Stream rule: o_data, o_single and o_last hold stable while o_valid=1 and i_ready=0.
- Simultaneous FIFO push and pop: count is unchanged, and ordering is preserved.
- Pair count = ceil(len/2). len=DEPTH reads every word exactly once, wrapping past DEPTH-1 to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN/DONE), FIFO depth constant 4, and the pair payload layout {last, single, hi, lo}.
- One sub-module: sram_rd_fifo, a synchronous 4-entry FIFO with payload width 2*WIDTH+2. It has push, pop, count and empty outputs, and an async active-low reset.

Test Plan:
- Back-to-back read, base=0, len=8, i_ready=1, SRAM preloaded word i = 16'hA000+i:
  - Expect 4 consecutive pairs 32'hA001A000, A003A002, A005A004, A007A006.
  - o_last only on the 4th pair; o_valid first high 2 edges after the start edge; o_done 1 cycle after the last pop.
- Odd length and wrap, base=14, len=5, DEPTH=16:
  - Addresses issued: 14/15, 0/1, 2/3.
  - The third pair has o_single=1, o_data=32'h0000A002 and o_last=1.
- Backpressure, len=16:
  - Hold i_ready=0 for 10 cycles after the first valid. Expect at most 4 pairs issued, o_ce_n=1 thereafter, and o_data stable.
  - Release i_ready. All 8 pairs are delivered in order with no loss or duplication.
- len=0:
  - o_done pulses exactly one cycle after the start edge.
  - o_ce_n stays 1 and o_valid stays 0 throughout.
- Reset mid-block, len=16:
  - Drop i_rst_n after 3 pairs are issued. All outputs go to reset values at once, and no o_done appears.
  - A subsequent start with len=2 returns the correct single pair.
- i_start pulsed while busy: ignored. The current block completes unchanged, with exactly one o_done.
